// File: rtl/pll_i2c_config.sv
// Boot-time register loader for the two clock-generator PLLs, one open-drain I2C bus each.
// Walks a synchronous-ROM table and issues one single-register write per entry.
module pll_i2c_config #(
  parameter int         CLK_FREQ    = 48_000_000,
  parameter int         I2C_FREQ    = 100_000,
  parameter logic [6:0] DEV_ADDR    = 7'h60,
  parameter int         NUM_ENTRIES = 64,
  localparam int        TW          = $clog2(NUM_ENTRIES)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [TW-1:0] tbl_addr,
  input  logic [16:0]   tbl_data,
  output logic          scl_a_oe,
  output logic          sda_a_oe,
  input  logic          sda_a_in,
  output logic          scl_b_oe,
  output logic          sda_b_oe,
  input  logic          sda_b_in
);

  localparam int              QUARTER   = CLK_FREQ / (4 * I2C_FREQ);
  localparam int              QW        = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam logic [QW-1:0]   Q_RELOAD  = QW'(QUARTER - 1);
  localparam logic [TW-1:0]   LAST_ADDR = TW'(NUM_ENTRIES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_START,
    ST_BYTE,
    ST_ACK,
    ST_STOP,
    ST_GAP,
    ST_FIN
  } state_t;

  state_t        state, state_nxt;
  logic [QW-1:0] qcnt, qcnt_nxt;
  logic [1:0]    phase, phase_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [1:0]    byte_idx, byte_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          fetch_wait, fetch_wait_nxt;
  logic          bus_sel, bus_sel_nxt;
  logic [7:0]    reg_byte, reg_byte_nxt;
  logic [7:0]    val_byte, val_byte_nxt;
  logic          nack, nack_nxt;
  logic          busy_nxt, done_nxt, error_nxt;
  logic [TW-1:0] tbl_addr_nxt;
  logic [1:0]    lines_nxt;
  logic          timed, tick, sample_now, sda_in_sel;

  // Line levels for a given phase as {scl_oe, sda_oe}; data is held for the whole bit.
  function automatic logic [1:0] line_decode(state_t st, logic [1:0] ph, logic b);
    logic [1:0] l;
    l = 2'b00;
    case (st)
      ST_START: l = ph[1] ? 2'b01 : 2'b00;
      ST_BYTE:  l = {(ph == 2'd0) || (ph == 2'd3), ~b};
      ST_ACK:   l = {(ph == 2'd0) || (ph == 2'd3), 1'b0};
      ST_STOP:  l = (ph == 2'd0) ? 2'b11 : 2'b01;
      default:  l = 2'b00;
    endcase
    return l;
  endfunction

  assign timed      = (state == ST_START) || (state == ST_BYTE) || (state == ST_ACK) ||
                      (state == ST_STOP)  || (state == ST_GAP);
  assign tick       = (qcnt == '0);
  assign sda_in_sel = bus_sel ? sda_b_in : sda_a_in;
  assign sample_now = (state == ST_ACK) && (phase == 2'd2) && (qcnt == Q_RELOAD);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state      <= ST_IDLE;
      qcnt       <= Q_RELOAD;
      phase      <= 2'd0;
      bit_idx    <= 3'd0;
      byte_idx   <= 2'd0;
      shreg      <= 8'h00;
      fetch_wait <= 1'b0;
      bus_sel    <= 1'b0;
      reg_byte   <= 8'h00;
      val_byte   <= 8'h00;
      nack       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      tbl_addr   <= '0;
      scl_a_oe   <= 1'b0;
      sda_a_oe   <= 1'b0;
      scl_b_oe   <= 1'b0;
      sda_b_oe   <= 1'b0;
    end else begin
      state      <= state_nxt;
      qcnt       <= qcnt_nxt;
      phase      <= phase_nxt;
      bit_idx    <= bit_idx_nxt;
      byte_idx   <= byte_idx_nxt;
      shreg      <= shreg_nxt;
      fetch_wait <= fetch_wait_nxt;
      bus_sel    <= bus_sel_nxt;
      reg_byte   <= reg_byte_nxt;
      val_byte   <= val_byte_nxt;
      nack       <= nack_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      error      <= error_nxt;
      tbl_addr   <= tbl_addr_nxt;
      // Outputs are registered from next-state values so they line up with the state register.
      scl_a_oe   <= lines_nxt[1] & ~bus_sel_nxt;
      sda_a_oe   <= lines_nxt[0] & ~bus_sel_nxt;
      scl_b_oe   <= lines_nxt[1] &  bus_sel_nxt;
      sda_b_oe   <= lines_nxt[0] &  bus_sel_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    phase_nxt      = phase;
    bit_idx_nxt    = bit_idx;
    byte_idx_nxt   = byte_idx;
    shreg_nxt      = shreg;
    fetch_wait_nxt = fetch_wait;
    bus_sel_nxt    = bus_sel;
    reg_byte_nxt   = reg_byte;
    val_byte_nxt   = val_byte;
    nack_nxt       = nack;
    busy_nxt       = busy;
    done_nxt       = done;
    error_nxt      = error;
    tbl_addr_nxt   = tbl_addr;
    qcnt_nxt       = (timed && !tick) ? (qcnt - QW'(1)) : Q_RELOAD;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt      = ST_FETCH;
          busy_nxt       = 1'b1;
          done_nxt       = 1'b0;
          error_nxt      = 1'b0;
          nack_nxt       = 1'b0;
          tbl_addr_nxt   = '0;
          fetch_wait_nxt = 1'b1;
        end
      end
      // First FETCH cycle covers the ROM read latency; the entry is latched on the second.
      ST_FETCH: begin
        if (fetch_wait) begin
          fetch_wait_nxt = 1'b0;
        end else begin
          {bus_sel_nxt, reg_byte_nxt, val_byte_nxt} = tbl_data;
          state_nxt = ST_START;
          phase_nxt = 2'd0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (phase == 2'd3) begin
            state_nxt    = ST_BYTE;
            phase_nxt    = 2'd0;
            bit_idx_nxt  = 3'd7;
            byte_idx_nxt = 2'd0;
            shreg_nxt    = {DEV_ADDR, 1'b0};
          end else begin
            phase_nxt = phase + 2'd1;
          end
        end
      end
      ST_BYTE: begin
        if (tick) begin
          if (phase == 2'd3) begin
            phase_nxt = 2'd0;
            if (bit_idx == 3'd0) begin
              state_nxt = ST_ACK;
            end else begin
              bit_idx_nxt = bit_idx - 3'd1;
              shreg_nxt   = {shreg[6:0], 1'b0};
            end
          end else begin
            phase_nxt = phase + 2'd1;
          end
        end
      end
      ST_ACK: begin
        if (sample_now && sda_in_sel) begin
          nack_nxt  = 1'b1;
          error_nxt = 1'b1;
        end
        if (tick) begin
          if (phase == 2'd3) begin
            phase_nxt = 2'd0;
            if (nack || (byte_idx == 2'd2)) begin
              state_nxt = ST_STOP;
            end else begin
              state_nxt    = ST_BYTE;
              bit_idx_nxt  = 3'd7;
              byte_idx_nxt = byte_idx + 2'd1;
              shreg_nxt    = (byte_idx == 2'd0) ? reg_byte : val_byte;
            end
          end else begin
            phase_nxt = phase + 2'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (phase == 2'd2) begin
            state_nxt = ST_GAP;
            phase_nxt = 2'd0;
          end else begin
            phase_nxt = phase + 2'd1;
          end
        end
      end
      // A NACK aborts the rest of the table after the bus-free gap.
      ST_GAP: begin
        if (tick) begin
          if (phase == 2'd3) begin
            phase_nxt = 2'd0;
            if (nack || (tbl_addr == LAST_ADDR)) begin
              state_nxt = ST_FIN;
            end else begin
              tbl_addr_nxt   = tbl_addr + TW'(1);
              state_nxt      = ST_FETCH;
              fetch_wait_nxt = 1'b1;
            end
          end else begin
            phase_nxt = phase + 2'd1;
          end
        end
      end
      ST_FIN: begin
        busy_nxt  = 1'b0;
        done_nxt  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    lines_nxt = line_decode(state_nxt, phase_nxt, shreg_nxt[7]);
  end

endmodule

// File: tb/tb_pll_i2c_config.sv
// Directed bench for pll_i2c_config: two-entry table with byte-decoding slave models on both
// buses (QUARTER=1), plus a default-parameter instance for SCL timing.
module tb_pll_i2c_config;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        nreset = 1'b0, start = 1'b0;
  logic        busy, done, error;
  logic [0:0]  tbl_addr;
  logic [16:0] tbl_data;
  logic        scl_a_oe, sda_a_oe, sda_a_in, scl_b_oe, sda_b_oe, sda_b_in;
  logic [16:0] rom [2];

  pll_i2c_config #(.CLK_FREQ(400_000), .I2C_FREQ(100_000), .DEV_ADDR(7'h60), .NUM_ENTRIES(2)) dut (
    .clk(clk), .nreset(nreset), .start(start), .busy(busy), .done(done), .error(error),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .scl_a_oe(scl_a_oe), .sda_a_oe(sda_a_oe), .sda_a_in(sda_a_in),
    .scl_b_oe(scl_b_oe), .sda_b_oe(sda_b_oe), .sda_b_in(sda_b_in));

  always @(posedge clk) tbl_data <= rom[tbl_addr];

  logic        nreset2 = 1'b0, start2 = 1'b0;
  logic        busy2, done2, error2;
  logic [5:0]  tbl_addr2;
  logic [16:0] tbl_data2 = 17'h00A5C;
  logic        scl_a2_oe, sda_a2_oe, scl_b2_oe, sda_b2_oe;
  logic        sda_a2_in = 1'b0, sda_b2_in = 1'b0;

  pll_i2c_config dut2 (
    .clk(clk), .nreset(nreset2), .start(start2), .busy(busy2), .done(done2), .error(error2),
    .tbl_addr(tbl_addr2), .tbl_data(tbl_data2),
    .scl_a_oe(scl_a2_oe), .sda_a_oe(sda_a2_oe), .sda_a_in(sda_a2_in),
    .scl_b_oe(scl_b2_oe), .sda_b_oe(sda_b2_oe), .sda_b_in(sda_b2_in));

  // Open-drain bus lines with pull-ups, wire-ANDed with the slave ACK pull.
  logic pull_a = 1'b0, pull_b = 1'b0;
  logic scl_a, sda_a, scl_b, sda_b;
  assign scl_a    = ~scl_a_oe;
  assign sda_a    = ~(sda_a_oe | pull_a);
  assign sda_a_in = sda_a;
  assign scl_b    = ~scl_b_oe;
  assign sda_b    = ~(sda_b_oe | pull_b);
  assign sda_b_in = sda_b;

  int         bitcnt_a = 0, bytenum_a = 0, nack_at_a = -1, stops_a = 0;
  int         bitcnt_b = 0, bytenum_b = 0, nack_at_b = -1, stops_b = 0;
  logic [7:0] sh_a = 8'h00, sh_b = 8'h00;
  logic [7:0] rx_a [$];
  logic [7:0] rx_b [$];

  // Slave A: START/STOP detection, bit capture on SCL rise, ACK driven between SCL falls.
  always @(negedge sda_a) if (scl_a === 1'b1) begin bitcnt_a = 0; bytenum_a = 0; end
  always @(posedge sda_a) if (scl_a === 1'b1) begin stops_a++; bitcnt_a = 0; pull_a = 1'b0; end
  always @(posedge scl_a) begin
    if (bitcnt_a < 8) begin sh_a = {sh_a[6:0], sda_a}; bitcnt_a++; end
    else if (bitcnt_a == 8) bitcnt_a = 9;
  end
  always @(negedge scl_a) begin
    if (bitcnt_a == 8) pull_a = (bytenum_a != nack_at_a);
    else if (bitcnt_a == 9) begin pull_a = 1'b0; rx_a.push_back(sh_a); bytenum_a++; bitcnt_a = 0; end
  end

  always @(negedge sda_b) if (scl_b === 1'b1) begin bitcnt_b = 0; bytenum_b = 0; end
  always @(posedge sda_b) if (scl_b === 1'b1) begin stops_b++; bitcnt_b = 0; pull_b = 1'b0; end
  always @(posedge scl_b) begin
    if (bitcnt_b < 8) begin sh_b = {sh_b[6:0], sda_b}; bitcnt_b++; end
    else if (bitcnt_b == 8) bitcnt_b = 9;
  end
  always @(negedge scl_b) begin
    if (bitcnt_b == 8) pull_b = (bytenum_b != nack_at_b);
    else if (bitcnt_b == 9) begin pull_b = 1'b0; rx_b.push_back(sh_b); bytenum_b++; bitcnt_b = 0; end
  end

  bit both_active = 1'b0, b_early = 1'b0;
  int b_activity = 0;
  always @(negedge clk) begin
    if ((scl_a_oe | sda_a_oe) && (scl_b_oe | sda_b_oe)) both_active = 1'b1;
    if (scl_b_oe | sda_b_oe) begin
      b_activity++;
      if (stops_a == 0) b_early = 1'b1;
    end
  end

  function automatic logic [7:0] q_at(input logic [7:0] q [$], input int i);
    return (i < q.size()) ? q[i] : 8'hxx;
  endfunction

  task automatic clear_slaves;
    bitcnt_a = 0; bytenum_a = 0; stops_a = 0; pull_a = 1'b0; rx_a.delete();
    bitcnt_b = 0; bytenum_b = 0; stops_b = 0; pull_b = 1'b0; rx_b.delete();
    both_active = 1'b0; b_early = 1'b0; b_activity = 0;
  endtask

  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    nreset = 1'b0; nreset2 = 1'b0; start = 1'b0; start2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({scl_a_oe, sda_a_oe, scl_b_oe, sda_b_oe} !== 4'b0000) begin errors++;
      $display("[TB] FAIL reset_oe: got %b expected 0000", {scl_a_oe, sda_a_oe, scl_b_oe, sda_b_oe}); end
    checks++; if ({busy, done, error} !== 3'b000) begin errors++;
      $display("[TB] FAIL reset_flags: got busy/done/error %b expected 000", {busy, done, error}); end
    checks++; if (tbl_addr !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_tbl_addr: got %0h expected 0", tbl_addr); end
    checks++; if ({busy2, done2, error2, scl_a2_oe, sda_a2_oe, scl_b2_oe, sda_b2_oe} !== 7'd0 || tbl_addr2 !== 6'd0) begin errors++;
      $display("[TB] FAIL reset_dut2: got flags/oe %b addr %0d expected all 0",
               {busy2, done2, error2, scl_a2_oe, sda_a2_oe, scl_b2_oe, sda_b2_oe}, tbl_addr2); end
    nreset = 1'b1; nreset2 = 1'b1;
    @(negedge clk);
    clear_slaves;
  endtask

  task automatic test_two_entries;
    logic [7:0] exp_a [3];
    logic [7:0] exp_b [3];
    bit ok;
    exp_a = '{8'hC0, 8'h03, 8'hFF};
    exp_b = '{8'hC0, 8'h10, 8'h4F};
    nack_at_a = -1; nack_at_b = -1;
    clear_slaves;
    pulse_start;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL t1_busy_after_start: got %b expected 1", busy); end
    wait_done(800, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL t1_done_timeout: got done=%b expected 1", done); end
    checks++; if (rx_a.size() != 3) begin errors++; $display("[TB] FAIL t1_a_count: got %0d expected 3", rx_a.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (q_at(rx_a, i) !== exp_a[i]) begin errors++;
        $display("[TB] FAIL t1_a_byte%0d: got %h expected %h", i, q_at(rx_a, i), exp_a[i]); end
      checks++; if (q_at(rx_b, i) !== exp_b[i]) begin errors++;
        $display("[TB] FAIL t1_b_byte%0d: got %h expected %h", i, q_at(rx_b, i), exp_b[i]); end
    end
    checks++; if (rx_b.size() != 3) begin errors++; $display("[TB] FAIL t1_b_count: got %0d expected 3", rx_b.size()); end
    checks++; if (b_early !== 1'b0) begin errors++; $display("[TB] FAIL t1_b_before_a_stop: got %b expected 0", b_early); end
    checks++; if (both_active !== 1'b0) begin errors++; $display("[TB] FAIL t1_both_buses: got %b expected 0", both_active); end
    checks++; if (stops_a != 1 || stops_b != 1) begin errors++;
      $display("[TB] FAIL t1_stops: got a=%0d b=%0d expected 1/1", stops_a, stops_b); end
    checks++; if ({busy, done, error} !== 3'b010) begin errors++;
      $display("[TB] FAIL t1_final_flags: got busy/done/error %b expected 010", {busy, done, error}); end
    checks++; if (tbl_addr !== 1'b1) begin errors++; $display("[TB] FAIL t1_tbl_addr: got %0h expected 1", tbl_addr); end
  endtask

  task automatic test_nack;
    bit ok;
    nack_at_a = 1; nack_at_b = -1;
    clear_slaves;
    pulse_start;
    wait_done(800, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL t2_done_timeout: got done=%b expected 1", done); end
    checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL t2_error: got %b expected 1", error); end
    checks++; if (rx_a.size() != 2 || q_at(rx_a, 0) !== 8'hC0 || q_at(rx_a, 1) !== 8'h03) begin errors++;
      $display("[TB] FAIL t2_a_bytes: got n=%0d %h %h expected 2 c0 03", rx_a.size(), q_at(rx_a, 0), q_at(rx_a, 1)); end
    checks++; if (stops_a != 1) begin errors++; $display("[TB] FAIL t2_a_stop: got %0d expected 1", stops_a); end
    checks++; if (b_activity != 0) begin errors++; $display("[TB] FAIL t2_b_driven: got %0d cycles expected 0", b_activity); end
    checks++; if (tbl_addr !== 1'b0) begin errors++; $display("[TB] FAIL t2_tbl_addr: got %0h expected 0", tbl_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t2_busy: got %b expected 0", busy); end
  endtask

  task automatic test_restart;
    bit ok;
    nack_at_a = -1;
    clear_slaves;
    pulse_start;
    checks++; if ({busy, done, error} !== 3'b100) begin errors++;
      $display("[TB] FAIL t3_accept_flags: got busy/done/error %b expected 100", {busy, done, error}); end
    wait_done(800, ok);
    checks++; if (!ok || error !== 1'b0) begin errors++;
      $display("[TB] FAIL t3_complete: got done=%b error=%b expected 1/0", done, error); end
    checks++; if (rx_b.size() != 3 || q_at(rx_b, 2) !== 8'h4F) begin errors++;
      $display("[TB] FAIL t3_b_bytes: got n=%0d last=%h expected 3 4f", rx_b.size(), q_at(rx_b, 2)); end
  endtask

  task automatic test_start_held;
    bit ok;
    bit seen_busy, seen_fall, seen_rerun;
    int low_cycles;
    seen_busy = 1'b0; seen_fall = 1'b0; seen_rerun = 1'b0; low_cycles = 0;
    clear_slaves;
    @(negedge clk); start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!seen_busy) begin
        if (busy === 1'b1) seen_busy = 1'b1;
      end else if (!seen_fall) begin
        if (busy === 1'b0) begin
          seen_fall = 1'b1; low_cycles = 1;
          checks++; if (stops_a != 1 || stops_b != 1 || done !== 1'b1) begin errors++;
            $display("[TB] FAIL t4_one_run: got stops a=%0d b=%0d done=%b expected 1/1/1", stops_a, stops_b, done); end
        end
      end else begin
        if (busy === 1'b1) begin
          seen_rerun = 1'b1;
          checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL t4_rerun_done: got %b expected 0", done); end
          break;
        end
        low_cycles++;
      end
    end
    start = 1'b0;
    checks++; if (!seen_fall || !seen_rerun || low_cycles < 1) begin errors++;
      $display("[TB] FAIL t4_busy_gap: got fall=%b rerun=%b low=%0d expected 1/1/>=1", seen_fall, seen_rerun, low_cycles); end
    wait_done(800, ok);
    checks++; if (!ok || stops_a != 2 || stops_b != 2) begin errors++;
      $display("[TB] FAIL t4_second_run: got done=%b stops a=%0d b=%0d expected 1/2/2", done, stops_a, stops_b); end
  endtask

  task automatic test_reset_midway;
    bit ok, found;
    found = 1'b0;
    clear_slaves;
    pulse_start;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rx_a.size() == 2 && bitcnt_a == 3) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL t5_reach_data_bit3: got 0 expected 1"); end
    nreset = 1'b0;
    @(negedge clk);
    checks++; if ({scl_a_oe, sda_a_oe, scl_b_oe, sda_b_oe} !== 4'b0000) begin errors++;
      $display("[TB] FAIL t5_oe_released: got %b expected 0000", {scl_a_oe, sda_a_oe, scl_b_oe, sda_b_oe}); end
    checks++; if ({busy, done, error} !== 3'b000 || tbl_addr !== 1'b0) begin errors++;
      $display("[TB] FAIL t5_flags: got busy/done/error %b addr %0h expected 000/0", {busy, done, error}, tbl_addr); end
    nreset = 1'b1;
    @(negedge clk);
    clear_slaves;
    pulse_start;
    wait_done(800, ok);
    checks++; if (!ok || error !== 1'b0) begin errors++;
      $display("[TB] FAIL t5_rerun: got done=%b error=%b expected 1/0", done, error); end
    checks++; if (rx_a.size() != 3 || q_at(rx_a, 0) !== 8'hC0 || q_at(rx_a, 1) !== 8'h03 || q_at(rx_a, 2) !== 8'hFF) begin errors++;
      $display("[TB] FAIL t5_a_bytes: got n=%0d %h %h %h expected 3 c0 03 ff",
               rx_a.size(), q_at(rx_a, 0), q_at(rx_a, 1), q_at(rx_a, 2)); end
    checks++; if (rx_b.size() != 3 || q_at(rx_b, 0) !== 8'hC0 || q_at(rx_b, 1) !== 8'h10 || q_at(rx_b, 2) !== 8'h4F) begin errors++;
      $display("[TB] FAIL t5_b_bytes: got n=%0d %h %h %h expected 3 c0 10 4f",
               rx_b.size(), q_at(rx_b, 0), q_at(rx_b, 1), q_at(rx_b, 2)); end
  endtask

  task automatic test_timing;
    int t_sda, t_scl, t_rel1, t_low1, t_rel2;
    bit b_touched;
    t_sda = -1; t_scl = -1; t_rel1 = -1; t_low1 = -1; t_rel2 = -1; b_touched = 1'b0;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    checks++; if (busy2 !== 1'b1) begin errors++; $display("[TB] FAIL t6_busy: got %b expected 1", busy2); end
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (scl_b2_oe | sda_b2_oe) b_touched = 1'b1;
      if (t_sda < 0) begin
        if (sda_a2_oe) t_sda = i;
      end else if (t_scl < 0) begin
        if (scl_a2_oe) t_scl = i;
      end else if (t_rel1 < 0) begin
        if (!scl_a2_oe) t_rel1 = i;
      end else if (t_low1 < 0) begin
        if (scl_a2_oe) t_low1 = i;
      end else if (!scl_a2_oe) begin
        t_rel2 = i; break;
      end
    end
    checks++; if (t_rel2 < 0) begin errors++; $display("[TB] FAIL t6_timeout: got incomplete edges expected 5 edges"); end
    checks++; if (t_scl - t_sda != 240) begin errors++; $display("[TB] FAIL t6_start_hold: got %0d expected 240", t_scl - t_sda); end
    checks++; if (t_low1 - t_rel1 != 240) begin errors++; $display("[TB] FAIL t6_scl_high: got %0d expected 240", t_low1 - t_rel1); end
    checks++; if (t_rel2 - t_rel1 != 480) begin errors++; $display("[TB] FAIL t6_scl_period: got %0d expected 480", t_rel2 - t_rel1); end
    checks++; if (b_touched) begin errors++; $display("[TB] FAIL t6_b_idle: got 1 expected 0"); end
    nreset2 = 1'b0;
    @(negedge clk);
    checks++; if ({scl_a2_oe, sda_a2_oe, busy2, done2} !== 4'b0000) begin errors++;
      $display("[TB] FAIL t6_reset_release: got %b expected 0000", {scl_a2_oe, sda_a2_oe, busy2, done2}); end
    nreset2 = 1'b1;
  endtask

  initial begin
    rom[0] = {1'b0, 8'h03, 8'hFF};
    rom[1] = {1'b1, 8'h10, 8'h4F};
    $display("[TB] starting pll_i2c_config bench");
    test_reset;
    test_two_entries;
    test_nack;
    test_restart;
    test_start_held;
    test_reset_midway;
    test_timing;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_i2c_config.md
Name: pll_i2c_config

Overview:
- Boot-time configurator for the two on-board clock-generator chips (PLL A, PLL B), each on its own open-drain I2C bus.
- On a start request, walks a register table and issues one I2C single-register write per entry to the bus that entry selects. Reports busy, done and NACK error.
- Sits beside the board controller in the peripheral clock domain. Replaces the permanently released SCL/SDA pins with driven open-drain enables.

Parameters:
- CLK_FREQ, 48_000_000: clk frequency in Hz.
- I2C_FREQ, 100_000: SCL frequency in Hz. QUARTER = CLK_FREQ/(4*I2C_FREQ) clk cycles per quarter bit (120 at defaults; must be >= 1).
- DEV_ADDR, 7'h60: 7-bit slave address, same on both buses.
- NUM_ENTRIES, 64: table length. TW = $clog2(NUM_ENTRIES).

Ports:
- clk  in  1  peripheral clock, all logic on posedge.
- nreset  in  1  synchronous active-low reset.
- start  in  1  single-cycle request to run the table; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done is set.
- done  out  1  sticky; set when the sequence ends (success or abort); cleared by the next accepted start.
- error  out  1  sticky NACK flag; valid when done=1; cleared by the next accepted start.
- tbl_addr  out  TW  table index.
- tbl_data  in  17  {bus_sel[16], reg[15:8], val[7:0]}; bus_sel 0 = PLL A, 1 = PLL B; valid one clk after tbl_addr changes (sync ROM).
- scl_a_oe, sda_a_oe  out  1 each  1 = pull PLL A line low, 0 = release.
- sda_a_in  in  1  PLL A SDA pin level (pre-synchronised).
- scl_b_oe, sda_b_oe  out  1 each  same for PLL B.
- sda_b_in  in  1  PLL B SDA pin level (pre-synchronised).

Behaviour:
- Reset (nreset=0 at posedge): all oe=0, busy=0, done=0, error=0, tbl_addr=0, state IDLE. Reset mid-transfer releases both buses on the next edge with no STOP generated.
- The bus not selected by the current entry has both oe=0 at all times.
- States: IDLE -> FETCH -> START -> BYTE -> ACK -> (BYTE | STOP) -> GAP -> FETCH or FIN.
- IDLE: waits for start. On start, sets busy=1, clears done/error, sets tbl_addr=0, goes to FETCH.
- FETCH: waits 1 clk, then latches tbl_data into bus_sel/reg/val.
- START: SDA released with SCL released for 2 quarters. Then SDA low for 2 quarters, then SCL low.
- BYTE: 8 bits, MSB first, in order {DEV_ADDR,1'b0}, reg, val. Each bit is 4 quarters:
  - q0: SCL low, set SDA (oe = ~bit).
  - q1: release SCL.
  - q2: SCL high.
  - q3: SCL low.
- ACK: same 4 quarters with SDA released; sda_in sampled on the first clk of q2. Low = ACK, high = NACK.
- After ACK: next byte if one remains, else STOP.
- STOP: SCL low with SDA low for 1 quarter, release SCL for 2 quarters, then release SDA.
- GAP: both lines released for 4 quarters (bus free time).
- After GAP: if tbl_addr == NUM_ENTRIES-1, go to FIN; else increment tbl_addr and go to FETCH.
- NACK on any byte: go straight to STOP, set error=1, then FIN (remaining entries skipped).
- FIN: busy=0, done=1, tbl_addr holds its last value, return to IDLE.
- No clock-stretching support: SCL is never sampled.
- Quarter timer: counts QUARTER-1 down to 0, reloads on every phase change.
- Entry cost without NACK: START 4 + 27 bit-times x 4 + STOP 3 + GAP 4 = 119 quarters, plus 1 FETCH clk.
- start asserted while busy has no effect. start in the same cycle as FIN is ignored; it is accepted on the next cycle.

Test Plan:
1. CLK_FREQ=400_000, I2C_FREQ=100_000 (QUARTER=1), NUM_ENTRIES=2; table {0,8'h03,8'hFF},{1,8'h10,8'h4F}; slave models always ACK; pulse start -> bus A decodes bytes 0xC0,0x03,0xFF; bus B decodes 0xC0,0x10,0x4F; B START follows A STOP; scl_b_oe/sda_b_oe stay 0 during entry 0; done=1, error=0, busy=0 after 2x120 clks.
2. Same setup, slave A NACKs the reg byte (0x03) -> STOP on A, error=1, done=1; bus B never driven; tbl_addr stays 0.
3. Pulse start again after test 2 with an always-ACK slave -> done and error clear on the accept edge; full sequence completes with error=0.
4. start held high for the whole run -> exactly one sequence; busy falls for at least 1 clk, then a second run begins.
5. nreset=0 during bus-A data byte bit 3 -> next edge all oe=0, busy=0, done=0, tbl_addr=0; a later start runs cleanly from entry 0.
6. Default parameters -> measure SCL high time = 240 clks and period = 480 clks (100 kHz at 48 MHz); START hold SDA-low-to-SCL-low = 240 clks.
